// File: rtl/imem_loader_pkg.sv
// Shared CPU package: instruction word width, instruction memory depth and
// the boot loader state enumeration.
package imem_loader_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI_BYTE,
    ST_LO_BYTE,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction memory boot loader. Assembles a big-endian byte stream into
// 16-bit instruction words, writes them to consecutive addresses starting at
// 0, and verifies a trailing XOR checksum byte. The CPU is held in reset for
// the whole session.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   load_start/load_length session request and word count (sampled in IDLE)
//   byte_valid/byte_data   incoming byte stream
//   byte_ready             loader accepts a byte this cycle
//   wr_enable/wr_address/wr_data  instruction memory write port
//   cpu_hold               ORed into the program counter reset
//   load_done              one-cycle pulse on successful completion
//   load_error             sticky error flag, cleared by the next accepted start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH      = IMEM_DEPTH,
  parameter int unsigned DATA_WIDTH = imem_loader_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_length,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] length_q;
  logic [BYTE_WIDTH-1:0] checksum;
  logic                  xfer;
  logic                  length_ok;

  assign xfer      = byte_valid && byte_ready;
  assign length_ok = (load_length != '0) && (32'(load_length) <= DEPTH);

  // Loader FSM; every output is a register updated alongside the state so
  // byte_ready/cpu_hold/load_done track the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      length_q   <= '0;
      checksum   <= '0;
      byte_ready <= 1'b0;
      wr_enable  <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            cpu_hold <= 1'b1;
            if (length_ok) begin
              state      <= ST_HI_BYTE;
              byte_ready <= 1'b1;
              wr_address <= '0;
              checksum   <= '0;
              load_error <= 1'b0;
              length_q   <= load_length;
            end else begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
            end
          end
        end
        ST_HI_BYTE: begin
          if (xfer) begin
            wr_data[15:8] <= byte_data;
            checksum      <= checksum ^ byte_data;
            state         <= ST_LO_BYTE;
          end
        end
        ST_LO_BYTE: begin
          if (xfer) begin
            wr_data[7:0] <= byte_data;
            checksum     <= checksum ^ byte_data;
            byte_ready   <= 1'b0;
            wr_enable    <= 1'b1;
            state        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Address only advances when another word follows, so it never
          // runs past the last valid location.
          byte_ready <= 1'b1;
          if (wr_address == ADDR_WIDTH'(length_q - 16'd1)) begin
            state <= ST_CHECK;
          end else begin
            wr_address <= wr_address + 16'd1;
            state      <= ST_HI_BYTE;
          end
        end
        ST_CHECK: begin
          if (xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == checksum) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
            end else begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
        end
        ST_ERROR: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions with a word-level
// expected-write model, a per-cycle write monitor and literal pins.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic [15:0] load_length;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_enable;
  logic [15:0] wr_address;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  imem_loader #(.DEPTH(DEPTH), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_length(load_length),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_enable  (wr_enable),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem_cap[0:DEPTH-1];
  logic [15:0] last_addr;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  bit          prev_we  = 1'b0;
  bit          prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] r = 8'h00;
    foreach (q[i]) r = r ^ q[i];
    return r;
  endfunction

  // Every write must be the next word the model expects; strobes are single-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("addr_in_range", 32'(wr_address <= 16'(DEPTH - 1)), 32'd1);
      if (wr_enable) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("wr_address", 32'(wr_address), 32'(exp_q[0].addr));
          check("wr_data", 32'(wr_data), 32'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
        mem_cap[wr_address[7:0]] = wr_data;
        last_addr = wr_address;
        wr_cnt++;
      end
      check("wr_enable_single", 32'(wr_enable && prev_we), 32'd0);
      check("load_done_single", 32'(load_done && prev_done), 32'd0);
      if (load_done) done_cnt++;
      prev_we   = wr_enable;
      prev_done = load_done;
    end
  end

  task automatic start(input int len);
    load_start  = 1'b1;
    load_length = 16'(len);
    @(negedge clk);
    load_start  = 1'b0;
    load_length = 16'd3;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int w = 0; w < 64 && !byte_ready; w++) @(negedge clk);
    check("byte_accepted", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 64 && cpu_hold; w++) @(negedge clk);
    check("return_idle", 32'(cpu_hold), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_load(input int len, input logic [7:0] bytes[$], input logic [7:0] trailer,
                          input int gap, input bit mid_start);
    int w0;
    int d0;
    bit ok;
    w0 = wr_cnt;
    d0 = done_cnt;
    ok = (trailer == xsum(bytes));
    for (int i = 0; i < len; i++)
      exp_q.push_back('{addr: 16'(i), data: {bytes[2*i], bytes[2*i+1]}});
    start(len);
    for (int i = 0; i < 2 * len; i++) begin
      if (mid_start && i == 2) begin
        load_start  = 1'b1;
        load_length = 16'd7;
        @(negedge clk);
        load_start  = 1'b0;
      end
      send_byte(bytes[i], gap);
    end
    send_byte(trailer, gap);
    wait_idle();
    check("write_count", 32'(wr_cnt - w0), 32'(len));
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'(ok));
    check("load_error", 32'(load_error), 32'(!ok));
  endtask

  task automatic bad_start(input int len);
    int w0;
    w0 = wr_cnt;
    start(len);
    check("bad_len_error", 32'(load_error), 32'd1);
    check("bad_len_hold", 32'(cpu_hold), 32'd1);
    wait_idle();
    check("bad_len_sticky", 32'(load_error), 32'd1);
    check("bad_len_no_write", 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] big[$];
    int w0;

    reset       = 1'b1;
    load_start  = 1'b0;
    load_length = 16'd0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_enable", 32'(wr_enable), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_wr_address", 32'(wr_address), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    bq = {8'h12, 8'h34, 8'hAB, 8'hCD};
    check("model_checksum", 32'(xsum(bq)), 32'h40);

    // Good checksum
    run_load(2, bq, 8'h40, 0, 1'b0);
    check("mem0", 32'(mem_cap[0]), 32'h1234);
    check("mem1", 32'(mem_cap[1]), 32'hABCD);

    // Bad checksum: writes still land, error instead of done
    run_load(2, bq, 8'h41, 0, 1'b0);

    // Illegal lengths
    bad_start(0);
    bad_start(257);

    // Gapped bytes with an ignored mid-session start
    run_load(2, bq, 8'h40, 3, 1'b1);
    check("gap_mem1", 32'(mem_cap[1]), 32'hABCD);

    // Reset after the first word is written
    w0 = wr_cnt;
    exp_q.push_back('{addr: 16'd0, data: 16'h1234});
    exp_q.push_back('{addr: 16'd1, data: 16'hABCD});
    start(2);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("first_write_seen", 32'(wr_enable), 32'd1);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_byte_ready", 32'(byte_ready), 32'd0);
    check("abort_wr_enable", 32'(wr_enable), 32'd0);
    check("abort_cpu_hold", 32'(cpu_hold), 32'd0);
    check("abort_load_done", 32'(load_done), 32'd0);
    check("abort_load_error", 32'(load_error), 32'd0);
    check("abort_wr_address", 32'(wr_address), 32'd0);
    check("abort_wr_data", 32'(wr_data), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_one_write", 32'(wr_cnt - w0), 32'd1);
    run_load(2, bq, 8'h40, 0, 1'b0);

    // Full-depth load
    for (int i = 0; i < 512; i++) big.push_back(8'(i * 37 + 5));
    run_load(256, big, xsum(big), 0, 1'b0);
    check("full_last_addr", 32'(last_addr), 32'd255);
    check("full_last_word", 32'(mem_cap[255]), 32'hBBE0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
